multicycle_ctrl: RTL

// - Multicycle LEGv8 control FSM sequencing fetch/decode/execute/memory/writeback.
// - Holds the instruction register; drives immediate_gen is_d_type, ALU, regfile, PC and memory selects.
// - Handshakes instruction and data memories (req/ack) with a timeout watchdog.
// - Sits between the memories and the datapath (regfile, ALU, immediate_gen, PC logic).

---
 rtl/cpu_ctrl_pkg.sv | 87 ++++++++
 rtl/ctrl_decode.sv | 51 +++++
 rtl/multicycle_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multicycle LEGv8 controller: FSM states,
// ALU operation codes, instruction classes and the per-instruction control word.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD    = 3'd0,
        ALU_SUB    = 3'd1,
        ALU_AND    = 3'd2,
        ALU_EOR    = 3'd3,
        ALU_LSR    = 3'd4,
        ALU_PASS_B = 3'd5
    } alu_op_t;

    typedef enum logic [3:0] {
        CLS_ILLEGAL,
        CLS_ADDI,
        CLS_ADDS,
        CLS_SUBS,
        CLS_AND,
        CLS_EOR,
        CLS_LSR,
        CLS_LDUR,
        CLS_STUR,
        CLS_B,
        CLS_CBZ,
        CLS_BLT
    } instr_class_t;

    localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
    localparam logic [10:0] OP_ADDS  = 11'b10101011000;
    localparam logic [10:0] OP_SUBS  = 11'b11101011000;
    localparam logic [10:0] OP_AND   = 11'b10001010000;
    localparam logic [10:0] OP_EOR   = 11'b11001010000;
    localparam logic [10:0] OP_LSR   = 11'b11010011010;
    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    localparam logic [5:0]  OP_B     = 6'b000101;
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;
    localparam logic [4:0]  COND_LT  = 5'b01011;

    localparam logic [1:0] PC_SRC_SEQ   = 2'b00;
    localparam logic [1:0] PC_SRC_IMM26 = 2'b01;
    localparam logic [1:0] PC_SRC_IMM19 = 2'b10;

    typedef struct packed {
        logic    legal;
        alu_op_t alu_op;
        logic    alu_src_imm;
        logic    is_d_type;
        logic    reg2_sel_rt;
        logic    mem_to_reg;
        logic    set_flags;
        logic    is_mem;
        logic    is_store;
        logic    is_branch;
    } ctrl_word_t;

    // Longest opcodes are tested first so the shorter prefixes cannot shadow them.
    function automatic instr_class_t classify(input logic [10:0] op, input logic [4:0] cond);
        instr_class_t c;
        c = CLS_ILLEGAL;
        if (op == OP_ADDS)                              c = CLS_ADDS;
        else if (op == OP_SUBS)                         c = CLS_SUBS;
        else if (op == OP_AND)                          c = CLS_AND;
        else if (op == OP_EOR)                          c = CLS_EOR;
        else if (op == OP_LSR)                          c = CLS_LSR;
        else if (op == OP_LDUR)                         c = CLS_LDUR;
        else if (op == OP_STUR)                         c = CLS_STUR;
        else if (op[10:1] == OP_ADDI)                   c = CLS_ADDI;
        else if (op[10:3] == OP_CBZ)                    c = CLS_CBZ;
        else if (op[10:3] == OP_BCOND && cond == COND_LT) c = CLS_BLT;
        else if (op[10:5] == OP_B)                      c = CLS_B;
        return c;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode: IR opcode field -> instruction class and
// the control word used by the DECODE legality check and EXEC/MEM/WB outputs.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [10:0]  opcode,
    input  logic [4:0]   cond,
    output instr_class_t cls,
    output ctrl_word_t   ctrl
);

    always_comb begin
        cls = classify(opcode, cond);
        ctrl = '0;
        ctrl.alu_op = ALU_ADD;
        ctrl.legal = (cls != CLS_ILLEGAL);
        case (cls)
            CLS_ADDI: ctrl.alu_src_imm = 1'b1;
            CLS_ADDS: ctrl.set_flags = 1'b1;
            CLS_SUBS: begin
                ctrl.alu_op = ALU_SUB;
                ctrl.set_flags = 1'b1;
            end
            CLS_AND:  ctrl.alu_op = ALU_AND;
            CLS_EOR:  ctrl.alu_op = ALU_EOR;
            CLS_LSR:  ctrl.alu_op = ALU_LSR;
            CLS_LDUR: begin
                ctrl.alu_src_imm = 1'b1;
                ctrl.is_d_type = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.is_mem = 1'b1;
            end
            CLS_STUR: begin
                ctrl.alu_src_imm = 1'b1;
                ctrl.is_d_type = 1'b1;
                ctrl.reg2_sel_rt = 1'b1;
                ctrl.is_mem = 1'b1;
                ctrl.is_store = 1'b1;
            end
            CLS_B:    ctrl.is_branch = 1'b1;
            CLS_CBZ: begin
                ctrl.alu_op = ALU_PASS_B;
                ctrl.reg2_sel_rt = 1'b1;
                ctrl.is_branch = 1'b1;
            end
            CLS_BLT:  ctrl.is_branch = 1'b1;
            default:  ctrl.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle LEGv8 control FSM: holds the IR, sequences fetch/decode/execute/
// memory/writeback and guards both memory handshakes with a timeout watchdog.
//
// state    | meaning
// ---------+-------------------------------------------------
// S_IDLE   | after reset, all outputs low, go fetch next cycle
// S_FETCH  | imem_req high until ack; IR loaded on ack
// S_DECODE | legality check of IR
// S_EXEC   | ALU selects; branches resolve and retire here
// S_MEM    | dmem_req high until ack; STUR retires here
// S_WB     | register write, flags, PC+4
// S_ERROR  | err high, everything else low until reset
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        dmem_ack,
    input  logic        alu_zero,
    input  logic        flag_n,
    input  logic        flag_v,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] instr,
    output logic        is_d_type,
    output logic        alu_src_imm,
    output logic [2:0]  alu_op,
    output logic        reg2_sel_rt,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        set_flags,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        err
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] WD_LIMIT = CW'(MEM_TIMEOUT);

    state_t       state, state_next;
    logic [31:0]  ir;
    logic [CW-1:0] wd_cnt, wd_inc;
    logic         mem_req, mem_ack, wd_expire;
    instr_class_t cls;
    ctrl_word_t   ctrl;

    ctrl_decode u_decode (
        .opcode (ir[31:21]),
        .cond   (ir[4:0]),
        .cls    (cls),
        .ctrl   (ctrl)
    );

    assign mem_req = (state == S_FETCH) || (state == S_MEM);
    assign mem_ack = ((state == S_FETCH) && imem_ack) || ((state == S_MEM) && dmem_ack);
    assign wd_inc = wd_cnt + 1'b1;
    // Expire on the cycle whose miss would take the count to the limit; an ack that cycle wins.
    assign wd_expire = mem_req && !mem_ack && (wd_inc == WD_LIMIT);
    assign instr = (state == S_ERROR) ? '0 : ir;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            ir     <= '0;
            wd_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == S_FETCH && imem_ack)
                ir <= imem_rdata;
            if (state_next != state)
                wd_cnt <= '0;
            else if (mem_req && !mem_ack && wd_cnt != WD_LIMIT)
                wd_cnt <= wd_inc;
        end
    end

    always_comb begin
        state_next  = state;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        is_d_type   = 1'b0;
        alu_src_imm = 1'b0;
        alu_op      = ALU_ADD;
        reg2_sel_rt = 1'b0;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;
        set_flags   = 1'b0;
        pc_write    = 1'b0;
        pc_src      = PC_SRC_SEQ;
        err         = 1'b0;
        case (state)
            S_IDLE: state_next = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack)       state_next = S_DECODE;
                else if (wd_expire) state_next = S_ERROR;
            end
            S_DECODE: state_next = ctrl.legal ? S_EXEC : S_ERROR;
            S_EXEC: begin
                alu_op      = ctrl.alu_op;
                alu_src_imm = ctrl.alu_src_imm;
                is_d_type   = ctrl.is_d_type;
                reg2_sel_rt = ctrl.reg2_sel_rt;
                if (ctrl.is_branch) begin
                    pc_write   = 1'b1;
                    state_next = S_FETCH;
                    case (cls)
                        CLS_B:   pc_src = PC_SRC_IMM26;
                        CLS_CBZ: pc_src = alu_zero ? PC_SRC_IMM19 : PC_SRC_SEQ;
                        CLS_BLT: pc_src = (flag_n != flag_v) ? PC_SRC_IMM19 : PC_SRC_SEQ;
                        default: pc_src = PC_SRC_SEQ;
                    endcase
                end else if (ctrl.is_mem) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                dmem_req    = 1'b1;
                dmem_we     = ctrl.is_store;
                alu_op      = ctrl.alu_op;
                alu_src_imm = ctrl.alu_src_imm;
                is_d_type   = ctrl.is_d_type;
                reg2_sel_rt = ctrl.reg2_sel_rt;
                if (dmem_ack) begin
                    if (ctrl.is_store) begin
                        pc_write   = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (wd_expire) begin
                    state_next = S_ERROR;
                end
            end
            S_WB: begin
                alu_op      = ctrl.alu_op;
                alu_src_imm = ctrl.alu_src_imm;
                is_d_type   = ctrl.is_d_type;
                reg_write   = 1'b1;
                pc_write    = 1'b1;
                mem_to_reg  = ctrl.mem_to_reg;
                set_flags   = ctrl.set_flags;
                state_next  = S_FETCH;
            end
            S_ERROR: err = 1'b1;
            default: state_next = S_ERROR;
        endcase
    end

endmodule
